mm_param: RTL and testbench
===========================

# mm_param

Parametrised streaming matrix multiplier, successor to the fixed 8-bit MM engine. It accepts matrix A and then matrix B row-major over a single byte-style input port, with column and row end markers, and checks shape legality. It then emits C = A·B row-major, one element per output pulse, with end-of-row marking. Data width, maximum dimension and signed/unsigned arithmetic are generalised. An explicit input-valid qualifier is added, so idle cycles between elements and between problems are safe.

## Interface
- DATA_W, 8, element width of A and B
- MAX_DIM, 15, maximum rows/cols of either matrix
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands
- OUT_W (localparam), 2*DATA_W + $clog2(MAX_DIM), result width (20 at defaults)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  element present on in_data; accepted only when busy=0
- in_data  in  DATA_W  matrix element
- col_end  in  1  element is last of its row
- row_end  in  1  element is last of its matrix; must coincide with col_end
- busy  out  1  high while checking, computing or outputting; inputs ignored
- valid  out  1  one-cycle output strobe
- is_legal  out  1  qualified by valid; 0 = shape error, result suppressed
- out_data  out  OUT_W (signed when SIGNED=1)  C element; 0 when is_legal=0
- change_row  out  1  qualified by valid; 1 on last element of each C row

## Operation
- States: LOAD_A, LOAD_B, CHECK, CALC, OUT, ERR. Reset state is LOAD_A.
- LOAD_A/LOAD_B: each accepted element is written at (r,c); c increments, and col_end sets c=0, r++.
  - The first row's length fixes the column count. Any later row of different length sets err_flag.
  - r or c reaching MAX_DIM sets err_flag; the write is discarded, counting continues.
  - row_end with col_end=0 sets err_flag.
  - row_end on A stores M=r+1, K=cols and moves to LOAD_B.
  - row_end on B stores Kb, N and moves to CHECK.
- CHECK (1 cycle): K≠Kb or err_flag → ERR, else CALC with i=j=k=0, acc=0.
- ERR (1 cycle): valid=1, is_legal=0, out_data=0, change_row=0. Next state LOAD_A; flags cleared.
- CALC: K cycles, acc += A[i][k]*B[k][j], sign- or zero-extended per SIGNED. Then OUT.
- OUT (1 cycle): valid=1, is_legal=1, out_data=acc, change_row=(j==N-1).
  - Advance j, wrapping to i.
  - After (M-1,N-1), go to LOAD_A; otherwise go to CALC with acc=0.
- Arithmetic is exact: OUT_W covers MAX_DIM products of full-scale operands in both modes, so there is no saturation and no wrap.

## Timing
- Reset values: busy=0, valid=0, is_legal=0, out_data=0, change_row=0. Counters, flags and state are cleared.
- All outputs are registered.
- busy rises the cycle after the edge that accepts B's row_end. It falls in the cycle after the final OUT or ERR.
- Latency:
  - ERR pulse is 2 cycles after the B row_end edge.
  - First valid is K+2 cycles after that edge.
  - Subsequent valids are every K+1 cycles.
- in_valid/col_end/row_end are ignored while busy=1. in_valid=0 cycles during loading are ignored, with no state change.
- The next problem may be offered on the first cycle busy=0.
- Reset asserted mid-operation aborts immediately: outputs drop to reset values and partial results are lost.

## Structure
- Package mm_pkg holds:
  - the state enum;
  - the index-width function clog2(MAX_DIM+1);
  - the OUT_W derivation function shared with testbenches.
- Sub-module mm_mac: DATA_W×DATA_W multiply-accumulate with SIGNED mode, a clear input and OUT_W accumulator.
- Top holds the A/B register arrays (MAX_DIM² × DATA_W each), load counters, shape registers, FSM and output registers.

## Test plan
- Unsigned 2×2·2×2, A=[1 2;3 4], B=[5 6;7 8] → valid outputs 19,22,43,50 with change_row 0,1,0,1, is_legal=1, 3 cycles apart.
- Shape mismatch, A 2×3, B 2×2 → exactly one valid with is_legal=0, out_data=0; busy low the next cycle; following 1×1 [3]·[4] gives 12.
- Full-scale unsigned, 15×15 of 0xFF times 15×15 of 0xFF → 225 outputs of 975375 (0xEE20F), change_row on every 15th.
- SIGNED=1:
  - [-128]·[-128] → 16384.
  - [-1 2]·[3;4] → 5 with change_row=1.
- Overflow and gaps: a 1×16 A row with random in_valid=0 gaps → single is_legal=0 pulse, and no array corruption on the next legal problem.
- Reset mid-stream: pull rst low after the 2nd output of a 3×3 problem → all outputs 0 at once; a fresh 2×2 afterwards is correct.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: shared types and width helpers for the mm_param matrix multiplier.
//   state_t      - controller states
//   idx_width()  - bits needed to count 0..max_dim inclusive
//   out_width()  - exact result width for max_dim full-scale products
package mm_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    CHECK,
    CALC,
    OUT,
    ERR
  } state_t;

  // Counters must reach max_dim itself so that "index hit MAX_DIM" is
  // representable as an overflow marker.
  function automatic int idx_width(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

  // Full-scale product needs 2*data_w bits; summing max_dim of them adds
  // clog2(max_dim) bits. Holds for both unsigned and two's-complement.
  function automatic int out_width(input int data_w, input int max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

endpackage

// File: rtl/mm_mac.sv
// mm_mac: DATA_W x DATA_W multiply-accumulate into an OUT_W accumulator.
//   clk, rst  - clock, asynchronous active-low reset
//   clear     - synchronous accumulator clear (wins over en)
//   en        - accumulate a*b this cycle
//   a, b      - operands, signed when SIGNED != 0
//   acc       - running sum
module mm_mac #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  acc
);

  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic [OUT_W-1:0] prod;

  // Extending both operands to the full accumulator width first makes the
  // truncated OUT_W product exact in two's complement for either mode.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{(OUT_W-DATA_W){a[DATA_W-1]}}, a};
      b_ext = {{(OUT_W-DATA_W){b[DATA_W-1]}}, b};
    end else begin
      a_ext = {{(OUT_W-DATA_W){1'b0}}, a};
      b_ext = {{(OUT_W-DATA_W){1'b0}}, b};
    end
  end

  assign prod = a_ext * b_ext;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/mm_param.sv
// mm_param: streaming matrix multiplier C = A*B.
//   A then B arrive row-major on in_data (qualified by in_valid), col_end
//   marks the last element of a row, row_end the last element of a matrix.
//   Shapes are checked; C is then streamed row-major, one element per valid.
//   clk, rst    - clock, asynchronous active-low reset
//   in_valid    - element present (ignored while busy)
//   in_data     - matrix element
//   col_end     - element closes its row
//   row_end     - element closes its matrix (must coincide with col_end)
//   busy        - checking / computing / outputting
//   valid       - one-cycle output strobe
//   is_legal    - 0 marks a shape error (out_data forced to 0)
//   out_data    - C element (two's complement when SIGNED != 0)
//   change_row  - set on the last element of each C row
module mm_param
  import mm_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int MAX_DIM = 15,
  parameter  int SIGNED  = 0,
  localparam int OUT_W   = out_width(DATA_W, MAX_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              col_end,
  input  logic              row_end,
  output logic              busy,
  output logic              valid,
  output logic              is_legal,
  output logic [OUT_W-1:0]  out_data,
  output logic              change_row
);

  localparam int             IDX_W   = idx_width(MAX_DIM);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_DIM);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_mem [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] b_mem [MAX_DIM][MAX_DIM];

  // Load position and shape bookkeeping.
  logic [IDX_W-1:0] r, c, cols;
  logic [IDX_W-1:0] m_dim, k_dim, kb_dim, n_dim;
  logic             err;

  // Compute indices: C[i][j] built over k.
  logic [IDX_W-1:0] i_idx, j_idx, k_idx;

  logic [OUT_W-1:0] acc;

  logic             load_en, in_range, load_we;
  logic [IDX_W-1:0] row_len, row_cols, r_inc, c_inc;
  logic [IDX_W-1:0] k_last, n_last, m_last;
  logic             last_elem;

  assign load_en  = in_valid && (state_q == LOAD_A || state_q == LOAD_B);
  assign in_range = (r != MAX_IDX) && (c != MAX_IDX);
  assign load_we  = load_en && in_range;

  // Counters saturate at MAX_DIM: once there the error flag is already set,
  // and saturation keeps a long row from wrapping back onto valid cells.
  assign r_inc    = (r == MAX_IDX) ? r : r + ONE;
  assign c_inc    = (c == MAX_IDX) ? c : c + ONE;
  assign row_len  = c + ONE;
  assign row_cols = (r == '0) ? row_len : cols;

  assign k_last    = k_dim - ONE;
  assign n_last    = n_dim - ONE;
  assign m_last    = m_dim - ONE;
  assign last_elem = (i_idx == m_last) && (j_idx == n_last);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD_A;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A: if (in_valid && row_end) state_d = LOAD_B;
      LOAD_B: if (in_valid && row_end) state_d = CHECK;
      CHECK:  state_d = (err || (k_dim != kb_dim)) ? ERR : CALC;
      CALC:   if (k_idx == k_last) state_d = OUT;
      OUT:    state_d = last_elem ? LOAD_A : CALC;
      ERR:    state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // ------------------------------------------------------------ storage
  // NOTE: the operand arrays carry no reset; every cell read during CALC is
  // written during the load of the same problem, and resetting two
  // MAX_DIM^2 arrays would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load_we) begin
      if (state_q == LOAD_A) a_mem[r][c] <= in_data;
      else                   b_mem[r][c] <= in_data;
    end
  end

  // ------------------------------------------------- load / shape logic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r      <= '0;
      c      <= '0;
      cols   <= '0;
      m_dim  <= '0;
      k_dim  <= '0;
      kb_dim <= '0;
      n_dim  <= '0;
      err    <= 1'b0;
    end else if (load_en) begin
      if (!in_range) err <= 1'b1;
      // A later row whose length differs from the first row is illegal.
      if (col_end && (r != '0) && (row_len != cols)) err <= 1'b1;
      if (row_end) begin
        if (!col_end) err <= 1'b1;
        if (state_q == LOAD_A) begin
          m_dim <= r + ONE;
          k_dim <= row_cols;
        end else begin
          kb_dim <= r + ONE;
          n_dim  <= row_cols;
        end
        r    <= '0;
        c    <= '0;
        cols <= '0;
      end else if (col_end) begin
        if (r == '0) cols <= row_len;
        r <= r_inc;
        c <= '0;
      end else begin
        c <= c_inc;
      end
    end else if (state_q == ERR || (state_q == OUT && last_elem)) begin
      err <= 1'b0;
    end
  end

  // -------------------------------------------------------- compute walk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_idx <= '0;
      j_idx <= '0;
      k_idx <= '0;
    end else begin
      case (state_q)
        CHECK: begin
          i_idx <= '0;
          j_idx <= '0;
          k_idx <= '0;
        end
        CALC: k_idx <= (k_idx == k_last) ? '0 : k_idx + ONE;
        OUT: begin
          if (j_idx == n_last) begin
            j_idx <= '0;
            i_idx <= i_idx + ONE;
          end else begin
            j_idx <= j_idx + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Accumulator is cleared in CHECK and in every OUT so each C element
  // starts from zero on the first CALC cycle.
  mm_mac #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == CHECK || state_q == OUT),
    .en    (state_q == CALC),
    .a     (a_mem[i_idx][k_idx]),
    .b     (b_mem[k_idx][j_idx]),
    .acc   (acc)
  );

  // ----------------------------------------------------- output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      valid      <= 1'b0;
      is_legal   <= 1'b0;
      out_data   <= '0;
      change_row <= 1'b0;
    end else begin
      // busy follows the next state so it drops together with the final
      // strobe and the next problem can be offered right away.
      busy       <= !(state_d == LOAD_A || state_d == LOAD_B);
      valid      <= (state_q == OUT) || (state_q == ERR);
      is_legal   <= (state_q == OUT);
      out_data   <= (state_q == OUT) ? acc : '0;
      change_row <= (state_q == OUT) && (j_idx == n_last);
    end
  end

endmodule

// File: tb/tb_mm_param.sv
// tb_mm_param: directed self-checking bench for mm_param.
// An unsigned and a signed instance share the input stimulus; a monitor
// records the strobed outputs of the selected instance with the edge
// number at which they appeared, so both values and latency are checked.
module tb_mm_param;
  import mm_pkg::*;

  localparam int OW = out_width(8, 15);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          col_end;
  logic          row_end;

  logic          busy_u, valid_u, legal_u, cr_u;
  logic [OW-1:0] data_u;
  logic          busy_s, valid_s, legal_s, cr_s;
  logic [OW-1:0] data_s;

  mm_param #(.DATA_W(8), .MAX_DIM(15), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .col_end(col_end), .row_end(row_end), .busy(busy_u), .valid(valid_u),
    .is_legal(legal_u), .out_data(data_u), .change_row(cr_u)
  );

  mm_param #(.DATA_W(8), .MAX_DIM(15), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .col_end(col_end), .row_end(row_end), .busy(busy_s), .valid(valid_s),
    .is_legal(legal_s), .out_data(data_s), .change_row(cr_s)
  );

  always #5 clk = ~clk;

  int edge_count = 0;
  always @(posedge clk) edge_count <= edge_count + 1;

  int total = 0;
  int bad   = 0;
  int e_edge = 0;
  bit sel_signed = 1'b0;

  logic [OW-1:0] q_data[$];
  bit            q_legal[$];
  bit            q_cr[$];
  bit            q_busy[$];
  int            q_edge[$];
  logic [7:0]    mbuf[$];

  always @(negedge clk) begin
    if (rst && (sel_signed ? valid_s : valid_u)) begin
      q_data.push_back(sel_signed ? data_s : data_u);
      q_legal.push_back(sel_signed ? legal_s : legal_u);
      q_cr.push_back(sel_signed ? cr_s : cr_u);
      q_busy.push_back(sel_signed ? busy_s : busy_u);
      q_edge.push_back(edge_count);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_legal.delete(); q_cr.delete();
    q_busy.delete(); q_edge.delete();
  endtask

  task automatic send_elem(input logic [7:0] d, input bit ce, input bit re);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; col_end = ce; row_end = re;
  endtask

  // Idle cycle with junk on the qualified lines.
  task automatic send_gap();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    col_end  = 1'($urandom_range(0, 1));
    row_end  = 1'($urandom_range(0, 1));
  endtask

  // Ends a load; e_edge becomes the edge that accepted the last element.
  task automatic release_in();
    @(negedge clk);
    e_edge = edge_count;
    in_valid = 1'b0; in_data = '0; col_end = 1'b0; row_end = 1'b0;
  endtask

  task automatic load_mat(input int rows, input int cols, input int gap_max);
    for (int rr = 0; rr < rows; rr++) begin
      for (int cc = 0; cc < cols; cc++) begin
        if (gap_max > 0) begin
          int g = $urandom_range(0, gap_max);
          for (int n = 0; n < g; n++) send_gap();
        end
        send_elem(mbuf[rr*cols+cc], cc == cols-1, (rr == rows-1) && (cc == cols-1));
      end
    end
  endtask

  task automatic wait_count(input int n, input int budget);
    int cnt = 0;
    while (q_data.size() < n && cnt < budget) begin
      @(negedge clk); #1;
      cnt++;
    end
  endtask

  // Waits for n strobes, lets a few more cycles pass and checks none extra.
  task automatic wait_outputs(input string tag, input int n, input int budget);
    wait_count(n, budget);
    repeat (5) @(negedge clk);
    #1;
    check({tag, "_count"}, 32'(q_data.size()), 32'(n));
  endtask

  task automatic check_out(input string tag, input int idx, input logic [OW-1:0] exp_d,
                           input bit exp_l, input bit exp_cr, input int exp_lat);
    int lat;
    if (idx < q_data.size()) begin
      lat = (idx == 0) ? q_edge[0] - e_edge : q_edge[idx] - q_edge[idx-1];
      check($sformatf("%s_data%0d", tag, idx), 32'(q_data[idx]), 32'(exp_d));
      check($sformatf("%s_legal%0d", tag, idx), 32'(q_legal[idx]), 32'(exp_l));
      check($sformatf("%s_cr%0d", tag, idx), 32'(q_cr[idx]), 32'(exp_cr));
      check($sformatf("%s_lat%0d", tag, idx), 32'(lat), 32'(exp_lat));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] exp_t1 [4];
    logic [OW-1:0] exp_t6 [4];
    exp_t1 = '{20'd19, 20'd22, 20'd43, 20'd50};
    exp_t6 = '{20'd2, 20'd2, 20'd1, 20'd7};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; col_end = 1'b0; row_end = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_u),  0);
    check("rst_valid", 32'(valid_u), 0);
    check("rst_legal", 32'(legal_u), 0);
    check("rst_data",  32'(data_u),  0);
    check("rst_cr",    32'(cr_u),    0);
    rst = 1'b1;
    @(negedge clk);

    // 2x2 unsigned
    clear_q();
    mbuf = '{8'd1, 8'd2, 8'd3, 8'd4}; load_mat(2, 2, 0);
    mbuf = '{8'd5, 8'd6, 8'd7, 8'd8}; load_mat(2, 2, 0);
    release_in();
    check("t1_busy_rise", 32'(busy_u), 1);
    wait_outputs("t1", 4, 100);
    for (int n = 0; n < 4; n++)
      check_out("t1", n, exp_t1[n], 1'b1, n[0], (n == 0) ? 4 : 3);
    check("t1_busy_end", 32'(busy_u), 0);

    // shape mismatch 2x3 * 2x2, then 1x1
    clear_q();
    mbuf = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}; load_mat(2, 3, 0);
    mbuf = '{8'd1, 8'd2, 8'd3, 8'd4}; load_mat(2, 2, 0);
    release_in();
    wait_outputs("t2", 1, 50);
    check_out("t2", 0, '0, 1'b0, 1'b0, 2);
    if (q_busy.size() > 0) check("t2_busy_at_err", 32'(q_busy[0]), 0);
    clear_q();
    mbuf = '{8'd3}; load_mat(1, 1, 0);
    mbuf = '{8'd4}; load_mat(1, 1, 0);
    release_in();
    wait_outputs("t2b", 1, 50);
    check_out("t2b", 0, 20'd12, 1'b1, 1'b1, 3);

    // full-scale unsigned 15x15 of 0xFF
    clear_q();
    mbuf.delete();
    for (int n = 0; n < 225; n++) mbuf.push_back(8'hFF);
    load_mat(15, 15, 0);
    load_mat(15, 15, 0);
    release_in();
    wait_outputs("t3", 225, 5000);
    for (int n = 0; n < 225; n++)
      check_out("t3", n, 20'hEE20F, 1'b1, (n % 15) == 14, (n == 0) ? 17 : 16);

    // 1x16 overflow with gaps, then a legal [2 3]*[4;5]
    clear_q();
    mbuf.delete();
    for (int n = 0; n < 16; n++) mbuf.push_back(8'd9);
    load_mat(1, 16, 3);
    mbuf = '{8'd1}; load_mat(1, 1, 0);
    release_in();
    wait_outputs("t4", 1, 50);
    check_out("t4", 0, '0, 1'b0, 1'b0, 2);
    clear_q();
    mbuf = '{8'd2, 8'd3}; load_mat(1, 2, 2);
    mbuf = '{8'd4, 8'd5}; load_mat(2, 1, 2);
    release_in();
    wait_outputs("t4b", 1, 50);
    check_out("t4b", 0, 20'd23, 1'b1, 1'b1, 4);

    // signed instance
    sel_signed = 1'b1;
    clear_q();
    mbuf = '{8'h80}; load_mat(1, 1, 0);
    mbuf = '{8'h80}; load_mat(1, 1, 0);
    release_in();
    wait_outputs("t5a", 1, 50);
    check_out("t5a", 0, 20'd16384, 1'b1, 1'b1, 3);
    clear_q();
    mbuf = '{8'hFF, 8'h02}; load_mat(1, 2, 0);
    mbuf = '{8'h03, 8'h04}; load_mat(2, 1, 0);
    release_in();
    wait_outputs("t5b", 1, 50);
    check_out("t5b", 0, 20'd5, 1'b1, 1'b1, 4);
    sel_signed = 1'b0;

    // reset after 2nd output of 3x3 * I
    clear_q();
    mbuf = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}; load_mat(3, 3, 0);
    mbuf = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1}; load_mat(3, 3, 0);
    release_in();
    wait_count(2, 100);
    check("t6_count", 32'(q_data.size()), 2);
    check_out("t6", 0, 20'd1, 1'b1, 1'b0, 5);
    check_out("t6", 1, 20'd2, 1'b1, 1'b0, 4);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid_u), 0);
    check("t6_rst_busy",  32'(busy_u),  0);
    check("t6_rst_data",  32'(data_u),  0);
    check("t6_rst_legal", 32'(legal_u), 0);
    @(negedge clk);
    rst = 1'b1;
    clear_q();
    mbuf = '{8'd2, 8'd0, 8'd1, 8'd3}; load_mat(2, 2, 0);
    mbuf = '{8'd1, 8'd1, 8'd0, 8'd2}; load_mat(2, 2, 0);
    release_in();
    wait_outputs("t6b", 4, 100);
    for (int n = 0; n < 4; n++)
      check_out("t6b", n, exp_t6[n], 1'b1, n[0], (n == 0) ? 4 : 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
